// File: rtl/serial_register_host_pkg.sv
// ============================================================================
// Module : serial_register_host_pkg
// Shared types and helpers for the serial register host.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package serial_register_host_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_SHIFT = 3'd1,
        RD_START = 3'd2,
        RD_SHIFT = 3'd3,
        RD_HOLD  = 3'd4
    } srh_state_t;

    // Bit-counter width for a SIZE-bit transfer; never narrower than one bit.
    function automatic int srh_cnt_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/srh_shifter.sv
// ============================================================================
// Module : srh_shifter
// SIZE-bit shift register shared by the serial write and read paths.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module srh_shifter #(
    parameter int SIZE      = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [SIZE-1:0] load_data,
    input  logic            shift_en,
    input  logic            ser_in,
    output logic            ser_out,
    output logic [SIZE-1:0] par_out
);

    logic [SIZE-1:0] r_data;
    logic [SIZE-1:0] w_shifted;

    // ser_out is the bit that reaches the output end after the next shift,
    // so a registered serial line can follow the shifter without lagging.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_shifted = {ser_in, r_data[SIZE-1:1]};
            assign ser_out   = r_data[1];
        end else begin : g_msb_first
            assign w_shifted = {r_data[SIZE-2:0], ser_in};
            assign ser_out   = r_data[SIZE-2];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= load_data;
        end else if (shift_en) begin
            r_data <= w_shifted;
        end
    end

    assign par_out = r_data;

endmodule

`default_nettype wire

// File: rtl/serial_register_host.sv
// ============================================================================
// Module : serial_register_host
// Host controller serializing parallel register reads/writes onto a bit stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module serial_register_host
    import serial_register_host_pkg::*;
#(
    parameter int SIZE      = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [SIZE-1:0] req_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [SIZE-1:0] rsp_rdata,
    output logic            sdout,
    output logic            swrite,
    output logic            sread,
    input  logic            sdin
);

    localparam int               CNT_W    = srh_cnt_width(SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SIZE - 1);

    srh_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_req_ready;
    logic            r_rsp_valid;
    logic [SIZE-1:0] r_rdata;
    logic            r_sdout;
    logic            r_swrite;
    logic            r_sread;

    logic            w_accept;
    logic            w_last;
    logic            w_first_bit;
    logic            w_load;
    logic [SIZE-1:0] w_load_data;
    logic            w_shift_en;
    logic            w_ser_in;
    logic            w_ser_out;
    logic [SIZE-1:0] w_par;
    logic [SIZE-1:0] w_assembled;

    assign w_accept    = req_valid & r_req_ready;
    assign w_last      = (r_cnt == LAST_CNT);
    assign w_first_bit = LSB_FIRST ? req_wdata[0] : req_wdata[SIZE-1];
    assign w_load      = ((r_state == IDLE) && w_accept && req_write) || (r_state == RD_START);
    assign w_load_data = (r_state == RD_START) ? '0 : req_wdata;
    assign w_shift_en  = (r_state == WR_SHIFT) || (r_state == RD_SHIFT);
    assign w_ser_in    = (r_state == RD_SHIFT) & sdin;

    // Word as it will stand once the final sdin bit is shifted in, so the
    // response is registered on the same edge that samples that bit.
    assign w_assembled = LSB_FIRST ? {sdin, w_par[SIZE-1:1]} : {w_par[SIZE-2:0], sdin};

    srh_shifter #(
        .SIZE      (SIZE),
        .LSB_FIRST (LSB_FIRST)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .load_data (w_load_data),
        .shift_en  (w_shift_en),
        .ser_in    (w_ser_in),
        .ser_out   (w_ser_out),
        .par_out   (w_par)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rdata     <= '0;
            r_sdout     <= 1'b0;
            r_swrite    <= 1'b0;
            r_sread     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_req_ready <= 1'b0;
                        r_cnt       <= '0;
                        if (req_write) begin
                            r_state  <= WR_SHIFT;
                            r_swrite <= 1'b1;
                            r_sdout  <= w_first_bit;
                        end else begin
                            r_state <= RD_START;
                            r_sread <= 1'b1;
                        end
                    end
                end
                WR_SHIFT: begin
                    if (w_last) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_swrite    <= 1'b0;
                        r_sdout     <= 1'b0;
                        r_req_ready <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_sdout <= w_ser_out;
                    end
                end
                RD_START: begin
                    r_sread <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= RD_SHIFT;
                end
                RD_SHIFT: begin
                    if (w_last) begin
                        r_state     <= RD_HOLD;
                        r_cnt       <= '0;
                        r_rsp_valid <= 1'b1;
                        r_rdata     <= w_assembled;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                RD_HOLD: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                    r_sdout     <= 1'b0;
                    r_swrite    <= 1'b0;
                    r_sread     <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign sdout     = r_sdout;
    assign swrite    = r_swrite;
    assign sread     = r_sread;

endmodule

`default_nettype wire

// File: tb/tb_serial_register_host.sv
// ============================================================================
// Module : tb_serial_register_host
// Directed bench driving an LSB-first and an MSB-first host in lockstep.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_serial_register_host;

    localparam int SIZE = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid;
    logic            req_write;
    logic [SIZE-1:0] req_wdata;
    logic            rsp_ready;
    logic            sdin;

    logic            req_ready_l, rsp_valid_l, sdout_l, swrite_l, sread_l;
    logic [SIZE-1:0] rsp_rdata_l;
    logic            req_ready_m, rsp_valid_m, sdout_m, swrite_m, sread_m;
    logic [SIZE-1:0] rsp_rdata_m;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_register_host #(.SIZE(SIZE), .LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_l),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_l), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_l),
        .sdout(sdout_l), .swrite(swrite_l), .sread(sread_l), .sdin(sdin)
    );

    serial_register_host #(.SIZE(SIZE), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready_m),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid_m), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_m),
        .sdout(sdout_m), .swrite(swrite_m), .sread(sread_m), .sdin(sdin)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // seq_l / seq_m: bit k is the k-th bit expected on sdout.
    task automatic write_seq(input logic [3:0] data, input logic [3:0] seq_l, input logic [3:0] seq_m);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = data;
        step();
        req_valid = 1'b0;
        req_wdata = ~data;
        for (int k = 0; k < SIZE; k++) begin
            check("wr_swrite", {30'd0, swrite_l, swrite_m}, 32'h3);
            check("wr_sdout_lsb", {31'd0, sdout_l}, {31'd0, seq_l[k]});
            check("wr_sdout_msb", {31'd0, sdout_m}, {31'd0, seq_m[k]});
            check("wr_busy", {28'd0, req_ready_l, req_ready_m, sread_l, sread_m}, 32'h0);
            step();
        end
        check("wr_done_ready", {30'd0, req_ready_l, req_ready_m}, 32'h3);
        check("wr_done_quiet", {28'd0, swrite_l, swrite_m, sdout_l, sdout_m}, 32'h0);
    endtask

    // Entered in the cycle right after a read was accepted.
    task automatic read_body(input logic [3:0] seq, input logic [3:0] exp_l,
                             input logic [3:0] exp_m, input int hold);
        check("rd_sread", {30'd0, sread_l, sread_m}, 32'h3);
        check("rd_busy", {30'd0, req_ready_l, req_ready_m}, 32'h0);
        for (int k = 0; k < SIZE; k++) begin
            step();
            sdin = seq[k];
            if (k == 0) check("rd_sread_pulse", {30'd0, sread_l, sread_m}, 32'h0);
        end
        step();
        sdin = 1'b0;
        check("rd_valid", {30'd0, rsp_valid_l, rsp_valid_m}, 32'h3);
        check("rd_data_lsb", {28'd0, rsp_rdata_l}, {28'd0, exp_l});
        check("rd_data_msb", {28'd0, rsp_rdata_m}, {28'd0, exp_m});
        for (int h = 0; h < hold; h++) begin
            step();
            check("bp_valid", {30'd0, rsp_valid_l, rsp_valid_m}, 32'h3);
            check("bp_data_lsb", {28'd0, rsp_rdata_l}, {28'd0, exp_l});
            check("bp_data_msb", {28'd0, rsp_rdata_m}, {28'd0, exp_m});
            check("bp_ready", {30'd0, req_ready_l, req_ready_m}, 32'h0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rd_released", {28'd0, rsp_valid_l, rsp_valid_m, req_ready_l, req_ready_m}, 32'h3);
        check("rd_data_kept", {24'd0, rsp_rdata_l, rsp_rdata_m}, {24'd0, exp_l, exp_m});
    endtask

    task automatic do_read(input logic [3:0] seq, input logic [3:0] exp_l,
                           input logic [3:0] exp_m, input int hold);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_wdata = 4'($urandom_range(0, 15));
        step();
        req_valid = 1'b0;
        read_body(seq, exp_l, exp_m, hold);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 4'hF;
        rsp_ready = 1'b0;
        sdin      = 1'b0;

        // Reset held with a pending request: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ready", {30'd0, req_ready_l, req_ready_m}, 32'h3);
            check("rst_serial", {26'd0, sdout_l, swrite_l, sread_l, sdout_m, swrite_m, sread_m}, 32'h0);
            check("rst_rsp", {30'd0, rsp_valid_l, rsp_valid_m}, 32'h0);
            check("rst_rdata", {24'd0, rsp_rdata_l, rsp_rdata_m}, 32'h0);
        end
        req_valid = 1'b0;
        rst_n     = 1'b1;
        step();
        check("post_rst_idle", {28'd0, req_ready_l, req_ready_m, swrite_l, swrite_m}, 32'hC);

        write_seq(4'b1011, 4'b1011, 4'b1101);
        do_read(4'b0110, 4'b0110, 4'b0110, 3);
        do_read(4'b0011, 4'b0011, 4'b1100, 0);
        write_seq(4'b0001, 4'b0001, 4'b1000);

        // Reset in the third bit cycle of a write.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 4'b1111;
        step();
        req_valid = 1'b0;
        step();
        step();
        check("mid_swrite_on", {30'd0, swrite_l, swrite_m}, 32'h3);
        rst_n = 1'b0;
        #1;
        check("mid_rst_quiet", {28'd0, swrite_l, swrite_m, sdout_l, sdout_m}, 32'h0);
        check("mid_rst_ready", {30'd0, req_ready_l, req_ready_m}, 32'h3);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("mid_after", {26'd0, swrite_l, swrite_m, sdout_l, sdout_m, req_ready_l, req_ready_m}, 32'h3);
        end

        // Write followed immediately by a read with req_valid held high.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_wdata = 4'hA;
        step();
        req_write = 1'b0;
        for (int k = 0; k < SIZE; k++) begin
            check("b2b_busy", {28'd0, req_ready_l, req_ready_m, sread_l, sread_m}, 32'h0);
            step();
        end
        check("b2b_ready_t5", {26'd0, req_ready_l, req_ready_m, sread_l, sread_m, swrite_l, swrite_m}, 32'h30);
        step();
        req_valid = 1'b0;
        read_body(4'b0001, 4'b0001, 4'b1000, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
